// File: rtl/add_sub_pkg.sv
// Shared types and defaults for the iterative adder/subtractor.
package add_sub_pkg;

    localparam int DEFAULT_WIDTH = 64;
    localparam int DEFAULT_SLICE = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic carry;
        logic overflow;
        logic zero;
    } flags_t;

endpackage

// File: rtl/add_sub_slice.sv
// Combinational SLICE-bit ripple adder; also exposes the carry into its top bit.
module add_sub_slice #(
    parameter int SLICE = 16
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    logic [SLICE:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < SLICE; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .sum  (sum[i]),
            .cout (carry[i+1])
        );
    end

    assign cout     = carry[SLICE];
    assign c_msb_in = carry[SLICE-1];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell used to build the slice ripple chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/add_sub_iter.sv
// Multi-cycle add/sub: one SLICE per cycle through a registered carry.
// Define ADD_SUB_ITER_WORD_EN to honour the RV64 *W `word` input.
module add_sub_iter
    import add_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SLICE = DEFAULT_SLICE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             sub,
    input  logic             word,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    if (WIDTH % SLICE != 0) begin : g_bad_slice
        $error("add_sub_iter: WIDTH must be a multiple of SLICE");
    end

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   a_reg, b_reg, result_reg, result_next;
    logic               carry_reg;
    flags_t             flags_reg, flags_next;
    logic               last;
    logic               zero_next;

    logic [SLICE-1:0]   a_slice, b_slice, slice_sum;
    logic               slice_cout, slice_c_msb;

    assign a_slice = a_reg[int'(cnt)*SLICE +: SLICE];
    assign b_slice = b_reg[int'(cnt)*SLICE +: SLICE];

    add_sub_slice #(.SLICE(SLICE)) u_slice (
        .a        (a_slice),
        .b        (b_slice),
        .cin      (carry_reg),
        .sum      (slice_sum),
        .cout     (slice_cout),
        .c_msb_in (slice_c_msb)
    );

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        result_next = result_reg;
        result_next[int'(cnt)*SLICE +: SLICE] = slice_sum;
    end

`ifdef ADD_SUB_ITER_WORD_EN
    localparam int WORD_NSLICE = 32 / SLICE;

    if (WIDTH != 64 || (32 % SLICE) != 0) begin : g_bad_word
        $error("add_sub_iter: word mode needs WIDTH==64 and 32 %% SLICE == 0");
    end

    logic word_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_reg <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            word_reg <= word;
        end
    end

    // Upper result bits may be stale in word mode; only bits 31:0 are ever observed.
    assign last      = word_reg ? (cnt == CNT_W'(WORD_NSLICE - 1)) : (cnt == CNT_W'(NSLICE - 1));
    assign zero_next = word_reg ? (result_next[31:0] == 32'd0) : (result_next == '0);
    assign sum_out   = word_reg ? {{(WIDTH-32){result_reg[31]}}, result_reg[31:0]} : result_reg;
`else
    logic unused_word;
    assign unused_word = word;

    assign last      = (cnt == CNT_W'(NSLICE - 1));
    assign zero_next = (result_next == '0);
    assign sum_out   = result_reg;
`endif

    assign flags_next.carry    = slice_cout;
    assign flags_next.overflow = slice_c_msb ^ slice_cout;
    assign flags_next.zero     = zero_next;

    // NOTE: the result and operand registers are reset too, so sum_out reads 0 under reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            carry_reg  <= 1'b0;
            result_reg <= '0;
            flags_reg  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            state <= state_next;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= in1;
                        b_reg     <= in2 ^ {WIDTH{sub}};
                        carry_reg <= sub;
                        cnt       <= '0;
                    end
                end
                BUSY: begin
                    result_reg <= result_next;
                    carry_reg  <= slice_cout;
                    cnt        <= cnt + CNT_W'(1);
                    if (last) begin
                        flags_reg <= flags_next;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = BUSY;
            end
            BUSY: begin
                if (last) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign carry_out = flags_reg.carry;
    assign overflow  = flags_reg.overflow;
    assign zero      = flags_reg.zero;

endmodule
